// File: rtl/fft_band_energy.sv
// Band-energy monitor on the FFT unload stream: approximate |X| per bin, summed into
// equal-width bands over the lower half-spectrum, with peak tracking and a handshaked drain.
module fft_band_energy #(
  parameter int DATA_WIDTH  = 38,
  parameter int INDEX_WIDTH = 13,
  parameter int BAND_BITS   = 3,
  parameter int ACC_WIDTH   = 48,
  parameter int SKIP_DC     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fft_valid,
  input  logic [INDEX_WIDTH-1:0] fft_index,
  input  logic [DATA_WIDTH-1:0]  fft_re,
  input  logic [DATA_WIDTH-1:0]  fft_im,
  input  logic                   band_ready,
  output logic                   band_valid,
  output logic [BAND_BITS-1:0]   band_id,
  output logic [ACC_WIDTH-1:0]   band_energy,
  output logic                   band_last,
  output logic                   frame_done,
  output logic [INDEX_WIDTH-2:0] peak_bin,
  output logic [DATA_WIDTH-1:0]  peak_mag,
  output logic                   busy,
  output logic                   overrun
);
  localparam int NUM_BANDS = 1 << BAND_BITS;
  localparam int BIN_WIDTH = INDEX_WIDTH - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_reg;
  logic                  s1_valid_reg, s1_keep_reg, s1_eof_reg;
  logic [DATA_WIDTH-1:0] s1_re_reg, s1_im_reg;
  logic [BAND_BITS-1:0]  s1_band_reg;
  logic [BIN_WIDTH-1:0]  s1_bin_reg;
  logic [ACC_WIDTH-1:0]  acc_reg [NUM_BANDS];
  logic [BAND_BITS-1:0]  drain_idx_reg;
  logic [DATA_WIDTH-1:0] peak_mag_reg;
  logic [BIN_WIDTH-1:0]  peak_bin_reg;
  logic                  frame_done_reg, overrun_reg;

  logic                  accept, keep_in, flush_done, last_accept, s2_update;
  logic [DATA_WIDTH-1:0] mag_max, mag_min, mag;
  logic [ACC_WIDTH:0]    acc_sum;
  logic [ACC_WIDTH-1:0]  acc_next;

  // Two's-complement magnitude; the most negative code has no positive twin, so clamp it.
  function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] r;
    if (!x[DATA_WIDTH-1])
      r = x;
    else if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      r = ~x + 1'b1;
    return r;
  endfunction

  // Once the end-of-frame bin is in stage 1, further samples wait for the drain and are lost.
  assign accept = fft_valid && ((state_reg == ST_IDLE) ||
                  ((state_reg == ST_ACCUM) && !(s1_valid_reg && s1_eof_reg)));
  assign keep_in = !fft_index[INDEX_WIDTH-1] &&
                   !((SKIP_DC != 0) && (fft_index == '0));
  assign flush_done  = (state_reg == ST_ACCUM) && s1_valid_reg && s1_eof_reg;
  assign last_accept = (state_reg == ST_DRAIN) && band_ready && (&drain_idx_reg);

  assign mag_max   = (s1_re_reg > s1_im_reg) ? s1_re_reg : s1_im_reg;
  assign mag_min   = (s1_re_reg > s1_im_reg) ? s1_im_reg : s1_re_reg;
  assign mag       = mag_max + (mag_min >> 1);
  assign s2_update = s1_valid_reg && s1_keep_reg;
  assign acc_sum   = {1'b0, acc_reg[s1_band_reg]} +
                     {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, mag};
  assign acc_next  = acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_keep_reg  <= 1'b0;
      s1_eof_reg   <= 1'b0;
      s1_re_reg    <= '0;
      s1_im_reg    <= '0;
      s1_band_reg  <= '0;
      s1_bin_reg   <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_keep_reg <= keep_in;
        s1_eof_reg  <= &fft_index;
        s1_re_reg   <= abs_sat(fft_re);
        s1_im_reg   <= abs_sat(fft_im);
        s1_band_reg <= fft_index[INDEX_WIDTH-2 -: BAND_BITS];
        s1_bin_reg  <= fft_index[BIN_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      drain_idx_reg  <= '0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_done_reg <= last_accept;
      if (fft_valid && !accept)
        overrun_reg <= 1'b1;
      case (state_reg)
        ST_IDLE:  if (fft_valid) state_reg <= ST_ACCUM;
        ST_ACCUM: if (flush_done) state_reg <= ST_DRAIN;
        ST_DRAIN: begin
          if (band_ready)
            drain_idx_reg <= drain_idx_reg + 1'b1;
          if (last_accept)
            state_reg <= ST_IDLE;
        end
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Strict compare: on equal magnitudes the earlier (lower) bin stays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_mag_reg <= '0;
      peak_bin_reg <= '0;
    end else if ((state_reg == ST_IDLE) && fft_valid) begin
      peak_mag_reg <= '0;
      peak_bin_reg <= '0;
    end else if (s2_update && (mag > peak_mag_reg)) begin
      peak_mag_reg <= mag;
      peak_bin_reg <= s1_bin_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          acc_reg[gi] <= '0;
        else if ((state_reg == ST_IDLE) || last_accept)
          acc_reg[gi] <= '0;
        else if (s2_update && (s1_band_reg == BAND_BITS'(gi)))
          acc_reg[gi] <= acc_next;
      end
    end
  endgenerate

  assign band_valid  = (state_reg == ST_DRAIN);
  assign band_id     = drain_idx_reg;
  assign band_energy = band_valid ? acc_reg[drain_idx_reg] : '0;
  assign band_last   = band_valid && (&drain_idx_reg);
  assign frame_done  = frame_done_reg;
  assign peak_bin    = peak_bin_reg;
  assign peak_mag    = peak_mag_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign overrun     = overrun_reg;
endmodule

// File: tb/tb_fft_band_energy.sv
// Directed bench for fft_band_energy: hand-computed band sums, peak, handshake,
// overrun, saturation and asynchronous reset.
module tb_fft_band_energy;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [12:0] fft_index = '0;
  logic [37:0] fft_re = '0;
  logic [37:0] fft_im = '0;
  logic        band_ready = 1'b0;
  logic        band_valid;
  logic [2:0]  band_id;
  logic [47:0] band_energy;
  logic        band_last;
  logic        frame_done;
  logic [11:0] peak_bin;
  logic [37:0] peak_mag;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] e_full [8];
  logic [47:0] e_expect [8];
  logic [37:0] neg_full;
  logic [47:0] max_mag;

  fft_band_energy dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_index(fft_index),
    .fft_re(fft_re), .fft_im(fft_im), .band_ready(band_ready),
    .band_valid(band_valid), .band_id(band_id), .band_energy(band_energy),
    .band_last(band_last), .frame_done(frame_done), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [37:0] re, input logic [37:0] im);
    fft_valid = 1'b1;
    fft_index = idx[12:0];
    fft_re    = re;
    fft_im    = im;
    tick();
  endtask

  task automatic stop_input();
    fft_valid = 1'b0;
    fft_re    = '0;
    fft_im    = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!band_valid && n < 100) begin
      tick();
      n++;
    end
    chk("drain_entry", band_valid, 1);
  endtask

  task automatic full_frame();
    for (int i = 0; i < 8192; i++)
      send(i, 38'd1000, 38'd0);
    stop_input();
  endtask

  task automatic drain(input string tag);
    band_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      chk({tag, "_id"}, band_id, b);
      chk({tag, "_energy"}, band_energy, e_expect[b]);
      chk({tag, "_last"}, band_last, (b == 7));
      tick();
    end
    chk({tag, "_done_pulse"}, frame_done, 1);
    chk({tag, "_valid_low"}, band_valid, 0);
    chk({tag, "_energy_idle"}, band_energy, 0);
    tick();
    chk({tag, "_done_end"}, frame_done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    e_full[0] = 48'd511000;
    for (int b = 1; b < 8; b++) e_full[b] = 48'd512000;
    neg_full = 38'h20_0000_0000;
    max_mag  = 48'd206158430206;

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", band_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_peak_mag", peak_mag, 0);
    rst = 1'b0;
    tick();

    // 1: full frame of constant magnitude, DC skipped
    full_frame();
    chk("s1_busy", busy, 1);
    wait_drain();
    chk("s1_peak_bin", peak_bin, 1);
    chk("s1_peak_mag", peak_mag, 1000);
    e_expect = e_full;
    drain("s1");
    chk("s1_peak_hold", peak_mag, 1000);

    // 2: single tone at bin 1500
    send(1500, -38'sd300, 38'sd400);
    send(8191, 38'd0, 38'd0);
    stop_input();
    wait_drain();
    chk("s2_peak_bin", peak_bin, 1500);
    chk("s2_peak_mag", peak_mag, 550);
    for (int b = 0; b < 8; b++) e_expect[b] = (b == 2) ? 48'd550 : 48'd0;
    drain("s2");

    // 3: backpressure, band b carries energy b+1
    for (int b = 0; b < 8; b++)
      send(b * 512 + 5, 38'(b + 1), 38'd0);
    send(8191, 38'd0, 38'd0);
    stop_input();
    band_ready = 1'b0;
    wait_drain();
    chk("s3_peak_bin", peak_bin, 3589);
    chk("s3_peak_mag", peak_mag, 8);
    for (int k = 0; k < 5; k++) begin
      chk("s3_hold_id", band_id, 0);
      chk("s3_hold_energy", band_energy, 1);
      chk("s3_hold_done", frame_done, 0);
      tick();
    end
    begin
      int b = 0;
      int cyc = 0;
      while (b < 8 && cyc < 64) begin
        chk("s3_id", band_id, b);
        chk("s3_energy", band_energy, b + 1);
        chk("s3_last", band_last, (b == 7));
        band_ready = (cyc % 2 == 0);
        tick();
        if (band_ready) b++;
        cyc++;
      end
      chk("s3_all_accepted", b, 8);
      chk("s3_done_pulse", frame_done, 1);
      chk("s3_valid_low", band_valid, 0);
    end
    band_ready = 1'b1;
    tick();
    chk("s3_done_end", frame_done, 0);

    // 4: overrun while draining
    chk("s4_overrun_pre", overrun, 0);
    send(100, 38'd0, -38'sd7);
    send(600, 38'd3, 38'd4);
    send(8191, 38'd0, 38'd0);
    stop_input();
    band_ready = 1'b0;
    wait_drain();
    for (int k = 0; k < 3; k++)
      send(100, 38'd1000, 38'd0);
    stop_input();
    chk("s4_overrun", overrun, 1);
    chk("s4_peak_bin", peak_bin, 100);
    chk("s4_peak_mag", peak_mag, 7);
    for (int b = 0; b < 8; b++) e_expect[b] = 48'd0;
    e_expect[0] = 48'd7;
    e_expect[1] = 48'd5;
    drain("s4");

    // 5: most negative inputs saturate |x|; then many of them saturate the accumulator
    send(10, neg_full, neg_full);
    send(8191, 38'd0, 38'd0);
    stop_input();
    wait_drain();
    chk("s5_overrun_sticky", overrun, 1);
    chk("s5_peak_bin", peak_bin, 10);
    chk("s5_peak_mag", peak_mag, max_mag);
    for (int b = 0; b < 8; b++) e_expect[b] = 48'd0;
    e_expect[0] = max_mag;
    drain("s5");
    for (int k = 0; k < 1400; k++)
      send(10, neg_full, neg_full);
    send(8191, 38'd0, 38'd0);
    stop_input();
    wait_drain();
    e_expect[0] = 48'hFFFF_FFFF_FFFF;
    drain("s5sat");

    // 6: asynchronous reset mid-frame, then a clean frame
    for (int i = 0; i <= 3000; i++)
      send(i, 38'd1000, 38'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_busy", busy, 0);
    chk("s6_overrun", overrun, 0);
    chk("s6_peak_mag", peak_mag, 0);
    chk("s6_peak_bin", peak_bin, 0);
    chk("s6_valid", band_valid, 0);
    stop_input();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("s6_idle_busy", busy, 0);
    full_frame();
    wait_drain();
    chk("s6_peak_bin2", peak_bin, 1);
    chk("s6_peak_mag2", peak_mag, 1000);
    e_expect = e_full;
    drain("s6");
    chk("s6_overrun_clean", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
